// File: rtl/clint_trap_ctrl_if.sv
// Signal bundle between the commit stage / CSR file / MMIO fabric and the CLINT trap sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding core's view.
interface clint_trap_ctrl_if;
  logic        i_inst_valid;
  logic [63:0] i_pc;
  logic        i_ecall;
  logic        i_mret;
  logic [63:0] i_csr_mtvec;
  logic [63:0] i_csr_mepc;
  logic [63:0] i_csr_mstatus;
  logic        i_global_int_en;
  logic        i_mtime_int_en;
  logic        i_mtime_int_pend;
  logic        o_clint_csr_wen;
  logic [11:0] o_clint_csr_waddr;
  logic [63:0] o_clint_csr_wdata;
  logic        o_redirect_valid;
  logic [63:0] o_redirect_pc;
  logic        o_stall;
  logic        i_mmio_wen;
  logic [63:0] i_mmio_addr;
  logic [63:0] i_mmio_wdata;
  logic [63:0] o_mmio_rdata;
  logic        o_timer_int;

  modport slave (
    input  i_inst_valid, i_pc, i_ecall, i_mret,
    input  i_csr_mtvec, i_csr_mepc, i_csr_mstatus,
    input  i_global_int_en, i_mtime_int_en, i_mtime_int_pend,
    output o_clint_csr_wen, o_clint_csr_waddr, o_clint_csr_wdata,
    output o_redirect_valid, o_redirect_pc, o_stall,
    input  i_mmio_wen, i_mmio_addr, i_mmio_wdata,
    output o_mmio_rdata, o_timer_int
  );

  modport master (
    output i_inst_valid, i_pc, i_ecall, i_mret,
    output i_csr_mtvec, i_csr_mepc, i_csr_mstatus,
    output i_global_int_en, i_mtime_int_en, i_mtime_int_pend,
    input  o_clint_csr_wen, o_clint_csr_waddr, o_clint_csr_wdata,
    input  o_redirect_valid, o_redirect_pc, o_stall,
    output i_mmio_wen, i_mmio_addr, i_mmio_wdata,
    input  o_mmio_rdata, o_timer_int
  );
endinterface

// File: rtl/clint_trap_ctrl.sv
// CLINT-side trap sequencer: owns mtime/mtimecmp, takes ecall/mret/timer interrupt at commit,
// writes mepc/mcause/mstatus one per cycle through the clint CSR port and redirects the PC.
module clint_trap_ctrl #(
  parameter logic [63:0] MTIME_ADDR    = 64'h0200_BFF8,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0200_4000,
  parameter int unsigned TICK_DIV      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  clint_trap_ctrl_if.slave         bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL = 64'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_MEPC,
    S_T_MCAUSE,
    S_T_MSTATUS,
    S_M_MSTATUS
  } state_t;

  state_t      r_state;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [PW-1:0] r_presc;
  logic [63:0] r_cause_q;

  logic        r_csr_wen;
  logic [11:0] r_csr_waddr;
  logic [63:0] r_csr_wdata;
  logic        r_redirect_valid;
  logic [63:0] r_redirect_pc;

  logic        w_idle;
  logic        w_int_take;
  logic        w_ecall_take;
  logic        w_mret_take;
  logic        w_tick;
  logic        w_wr_mtime;
  logic        w_wr_mtimecmp;
  logic [63:0] w_trap_mstatus;
  logic [63:0] w_mret_mstatus;
  logic        w_unused;

  assign w_idle       = (r_state == S_IDLE);
  assign w_int_take   = w_idle & bus.i_inst_valid & bus.i_global_int_en
                      & bus.i_mtime_int_en & bus.i_mtime_int_pend;
  assign w_ecall_take = w_idle & bus.i_inst_valid & bus.i_ecall;
  assign w_mret_take  = w_idle & bus.i_inst_valid & bus.i_mret;

  assign w_tick        = (r_presc == PW'(TICK_DIV - 1));
  assign w_wr_mtime    = bus.i_mmio_wen & (bus.i_mmio_addr == MTIME_ADDR);
  assign w_wr_mtimecmp = bus.i_mmio_wen & (bus.i_mmio_addr == MTIMECMP_ADDR);

  // mtvec is always treated as direct mode, so its mode bits are never consumed.
  assign w_unused = ^bus.i_csr_mtvec[1:0];

  always_comb begin
    // NOTE: every always_comb output is given a full default first so no path leaves it unassigned (no latch).
    w_trap_mstatus         = bus.i_csr_mstatus;
    w_trap_mstatus[7]      = bus.i_csr_mstatus[3];
    w_trap_mstatus[3]      = 1'b0;
    w_trap_mstatus[12:11]  = 2'b11;

    w_mret_mstatus         = bus.i_csr_mstatus;
    w_mret_mstatus[3]      = bus.i_csr_mstatus[7];
    w_mret_mstatus[7]      = 1'b1;
    w_mret_mstatus[12:11]  = 2'b11;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_presc    <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      // A software write to mtime overrides the increment in the same cycle.
      if (w_wr_mtime)  r_mtime <= bus.i_mmio_wdata;
      else if (w_tick) r_mtime <= r_mtime + 64'd1;
      if (w_wr_mtimecmp) r_mtimecmp <= bus.i_mmio_wdata;
    end
  end

  // Outputs are registered on the transition into each write state, so they are a pure
  // function of the current state from the CSR file's point of view.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_cause_q        <= '0;
      r_csr_wen        <= 1'b0;
      r_csr_waddr      <= '0;
      r_csr_wdata      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_csr_wen        <= 1'b0;
      r_csr_waddr      <= '0;
      r_csr_wdata      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_int_take || w_ecall_take) begin
            r_state     <= S_T_MEPC;
            r_cause_q   <= w_int_take ? CAUSE_MTI : CAUSE_ECALL;
            r_csr_wen   <= 1'b1;
            r_csr_waddr <= CSR_MEPC;
            r_csr_wdata <= bus.i_pc;
          end else if (w_mret_take) begin
            r_state          <= S_M_MSTATUS;
            r_csr_wen        <= 1'b1;
            r_csr_waddr      <= CSR_MSTATUS;
            r_csr_wdata      <= w_mret_mstatus;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= bus.i_csr_mepc;
          end
        end
        S_T_MEPC: begin
          r_state     <= S_T_MCAUSE;
          r_csr_wen   <= 1'b1;
          r_csr_waddr <= CSR_MCAUSE;
          r_csr_wdata <= r_cause_q;
        end
        S_T_MCAUSE: begin
          // mstatus and mtvec are stable here: the pipeline is frozen and CPU CSR writes are inhibited.
          r_state          <= S_T_MSTATUS;
          r_csr_wen        <= 1'b1;
          r_csr_waddr      <= CSR_MSTATUS;
          r_csr_wdata      <= w_trap_mstatus;
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= {bus.i_csr_mtvec[63:2], 2'b00};
        end
        S_T_MSTATUS, S_M_MSTATUS: r_state <= S_IDLE;
        default:                  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_clint_csr_wen   = r_csr_wen;
  assign bus.o_clint_csr_waddr = r_csr_waddr;
  assign bus.o_clint_csr_wdata = r_csr_wdata;
  assign bus.o_redirect_valid  = r_redirect_valid;
  assign bus.o_redirect_pc     = r_redirect_pc;
  assign bus.o_stall           = ~w_idle | w_int_take | w_ecall_take | w_mret_take;
  assign bus.o_timer_int       = (r_mtime >= r_mtimecmp);
  assign bus.o_mmio_rdata      = (bus.i_mmio_addr == MTIME_ADDR)    ? r_mtime    :
                                 (bus.i_mmio_addr == MTIMECMP_ADDR) ? r_mtimecmp : 64'd0;

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Directed self-checking bench for clint_trap_ctrl: timer, ecall/mret/interrupt sequences, reset abort.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_clint_trap_ctrl;
  localparam logic [63:0] MTIME_ADDR    = 64'h0200_BFF8;
  localparam logic [63:0] MTIMECMP_ADDR = 64'h0200_4000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  clint_trap_ctrl_if bus ();

  clint_trap_ctrl #(
    .MTIME_ADDR   (MTIME_ADDR),
    .MTIMECMP_ADDR(MTIMECMP_ADDR),
    .TICK_DIV     (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_inst_valid     = 1'b0;
    bus.i_pc             = '0;
    bus.i_ecall          = 1'b0;
    bus.i_mret           = 1'b0;
    bus.i_csr_mtvec      = '0;
    bus.i_csr_mepc       = '0;
    bus.i_csr_mstatus    = '0;
    bus.i_global_int_en  = 1'b0;
    bus.i_mtime_int_en   = 1'b0;
    bus.i_mtime_int_pend = 1'b0;
    bus.i_mmio_wen       = 1'b0;
    bus.i_mmio_addr      = MTIME_ADDR;
    bus.i_mmio_wdata     = '0;
  endtask

  task automatic mmio_write(input logic [63:0] addr, input logic [63:0] data);
    bus.i_mmio_wen   = 1'b1;
    bus.i_mmio_addr  = addr;
    bus.i_mmio_wdata = data;
    cyc(1);
    bus.i_mmio_wen   = 1'b0;
    bus.i_mmio_addr  = MTIME_ADDR;
  endtask

  task automatic present(input logic [63:0] pc, input logic ecall, input logic mret);
    bus.i_inst_valid = 1'b1;
    bus.i_pc         = pc;
    bus.i_ecall      = ecall;
    bus.i_mret       = mret;
  endtask

  task automatic retire_none();
    bus.i_inst_valid = 1'b0;
    bus.i_ecall      = 1'b0;
    bus.i_mret       = 1'b0;
  endtask

  // Full trap sequence with the expected cause; checks the mcause write and the final mstatus/redirect.
  task automatic run_trap(input string tag, input logic [63:0] pc, input logic [63:0] cause);
    present(pc, 1'b1, 1'b0);
    #1 check({tag, "_stall0"}, 64'(bus.o_stall), 64'd1);
    cyc(1);
    retire_none();
    check({tag, "_mepc_addr"}, 64'(bus.o_clint_csr_waddr), 64'h341);
    check({tag, "_mepc_data"}, bus.o_clint_csr_wdata, pc);
    cyc(1);
    check({tag, "_mcause_data"}, bus.o_clint_csr_wdata, cause);
    cyc(1);
    check({tag, "_mstatus_data"}, bus.o_clint_csr_wdata, 64'h1880);
    check({tag, "_redir"}, 64'(bus.o_redirect_valid), 64'd1);
    cyc(1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    rst = 1'b1;
    cyc(3);

    // Reset state, observed while reset is still asserted.
    check("rst_wen", 64'(bus.o_clint_csr_wen), 64'd0);
    check("rst_redir", 64'(bus.o_redirect_valid), 64'd0);
    check("rst_stall", 64'(bus.o_stall), 64'd0);
    check("rst_timer_int", 64'(bus.o_timer_int), 64'd0);
    check("rst_mtime", bus.o_mmio_rdata, 64'd0);
    bus.i_mmio_addr = MTIMECMP_ADDR;
    #1 check("rst_mtimecmp", bus.o_mmio_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.i_mmio_addr = MTIME_ADDR;
    rst = 1'b0;

    // Ten idle cycles at one tick per cycle.
    cyc(10);
    check("idle_mtime10", bus.o_mmio_rdata, 64'd10);
    check("idle_timer_int", 64'(bus.o_timer_int), 64'd0);
    check("idle_wen", 64'(bus.o_clint_csr_wen), 64'd0);
    bus.i_mmio_addr = 64'h0200_0000;
    #1 check("rdata_unmapped", bus.o_mmio_rdata, 64'd0);
    bus.i_mmio_addr = MTIME_ADDR;

    // Compare threshold at 20, count from 0.
    mmio_write(MTIMECMP_ADDR, 64'd20);
    mmio_write(MTIME_ADDR, 64'd0);
    check("mtime_loaded0", bus.o_mmio_rdata, 64'd0);
    cyc(19);
    check("mtime19", bus.o_mmio_rdata, 64'd19);
    check("timer_int_at19", 64'(bus.o_timer_int), 64'd0);
    cyc(1);
    check("mtime20", bus.o_mmio_rdata, 64'd20);
    check("timer_int_at20", 64'(bus.o_timer_int), 64'd1);

    // Write wins over the same-cycle tick.
    mmio_write(MTIME_ADDR, 64'h100);
    check("mtime_write_wins", bus.o_mmio_rdata, 64'h100);

    // Wrap at 2^64-1; mtimecmp back to max so the level stays low afterwards.
    mmio_write(MTIMECMP_ADDR, 64'hFFFF_FFFF_FFFF_FFFF);
    mmio_write(MTIME_ADDR, 64'hFFFF_FFFF_FFFF_FFFF);
    check("timer_int_eq_max", 64'(bus.o_timer_int), 64'd1);
    cyc(1);
    check("mtime_wrap", bus.o_mmio_rdata, 64'd0);
    check("timer_int_after_wrap", 64'(bus.o_timer_int), 64'd0);

    // ecall: three CSR writes then redirect; a same-time mret mid-sequence must be ignored.
    bus.i_csr_mtvec   = 64'h8000_0103;
    bus.i_csr_mstatus = 64'h8;
    present(64'h8000_0010, 1'b1, 1'b0);
    #1;
    check("ecall_stall_c0", 64'(bus.o_stall), 64'd1);
    check("ecall_wen_c0", 64'(bus.o_clint_csr_wen), 64'd0);
    cyc(1);
    retire_none();
    check("ecall_wen_c1", 64'(bus.o_clint_csr_wen), 64'd1);
    check("ecall_addr_c1", 64'(bus.o_clint_csr_waddr), 64'h341);
    check("ecall_data_c1", bus.o_clint_csr_wdata, 64'h8000_0010);
    check("ecall_redir_c1", 64'(bus.o_redirect_valid), 64'd0);
    check("ecall_stall_c1", 64'(bus.o_stall), 64'd1);
    cyc(1);
    present(64'h8000_0044, 1'b0, 1'b1);
    check("ecall_wen_c2", 64'(bus.o_clint_csr_wen), 64'd1);
    check("ecall_addr_c2", 64'(bus.o_clint_csr_waddr), 64'h342);
    check("ecall_data_c2", bus.o_clint_csr_wdata, 64'd11);
    check("ecall_stall_c2", 64'(bus.o_stall), 64'd1);
    cyc(1);
    retire_none();
    check("ecall_wen_c3", 64'(bus.o_clint_csr_wen), 64'd1);
    check("ecall_addr_c3", 64'(bus.o_clint_csr_waddr), 64'h300);
    check("ecall_data_c3", bus.o_clint_csr_wdata, 64'h1880);
    check("ecall_redir_c3", 64'(bus.o_redirect_valid), 64'd1);
    check("ecall_rpc_c3", bus.o_redirect_pc, 64'h8000_0100);
    check("ecall_stall_c3", 64'(bus.o_stall), 64'd1);
    cyc(1);
    check("ecall_wen_c4", 64'(bus.o_clint_csr_wen), 64'd0);
    check("ecall_redir_c4", 64'(bus.o_redirect_valid), 64'd0);
    check("ecall_stall_c4", 64'(bus.o_stall), 64'd0);

    // mret: single-cycle mstatus restore and redirect to mepc.
    bus.i_csr_mstatus = 64'h1880;
    bus.i_csr_mepc    = 64'h8000_0014;
    present(64'h8000_0100, 1'b0, 1'b1);
    #1 check("mret_stall_c0", 64'(bus.o_stall), 64'd1);
    cyc(1);
    retire_none();
    check("mret_wen_c1", 64'(bus.o_clint_csr_wen), 64'd1);
    check("mret_addr_c1", 64'(bus.o_clint_csr_waddr), 64'h300);
    check("mret_data_c1", bus.o_clint_csr_wdata, 64'h1888);
    check("mret_redir_c1", 64'(bus.o_redirect_valid), 64'd1);
    check("mret_rpc_c1", bus.o_redirect_pc, 64'h8000_0014);
    cyc(1);
    check("mret_wen_c2", 64'(bus.o_clint_csr_wen), 64'd0);
    check("mret_redir_c2", 64'(bus.o_redirect_valid), 64'd0);
    check("mret_stall_c2", 64'(bus.o_stall), 64'd0);

    // Pending timer interrupt outranks a simultaneous ecall; with MIE clear the ecall is taken.
    bus.i_csr_mstatus    = 64'h8;
    bus.i_mtime_int_en   = 1'b1;
    bus.i_mtime_int_pend = 1'b1;
    bus.i_global_int_en  = 1'b1;
    run_trap("irq", 64'h8000_0020, 64'h8000_0000_0000_0007);
    bus.i_global_int_en  = 1'b0;
    run_trap("noirq", 64'h8000_0024, 64'd11);
    bus.i_mtime_int_en   = 1'b0;
    bus.i_mtime_int_pend = 1'b0;

    // Reset during T_MCAUSE aborts the sequence.
    present(64'h8000_0030, 1'b1, 1'b0);
    cyc(1);
    retire_none();
    cyc(1);
    check("abort_mcause_addr", 64'(bus.o_clint_csr_waddr), 64'h342);
    rst = 1'b1;
    cyc(1);
    check("abort_wen", 64'(bus.o_clint_csr_wen), 64'd0);
    check("abort_redir", 64'(bus.o_redirect_valid), 64'd0);
    check("abort_stall", 64'(bus.o_stall), 64'd0);
    check("abort_mtime", bus.o_mmio_rdata, 64'd0);
    rst = 1'b0;
    cyc(1);
    check("abort_wen_after", 64'(bus.o_clint_csr_wen), 64'd0);
    check("abort_redir_after", 64'(bus.o_redirect_valid), 64'd0);
    check("abort_stall_after", 64'(bus.o_stall), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clint_trap_ctrl.md
Name: clint_trap_ctrl

Overview:
Trap sequencer and timer on the CLINT side of the CSR file's clint port. It owns mtime/mtimecmp, which software accesses by MMIO, and drives the timer-interrupt level into the CSR file. It detects ecall, mret and the machine timer interrupt at the commit point. It then writes mepc/mcause/mstatus through the single clint CSR write port, one CSR per cycle, and redirects the PC.

Parameters:
MTIME_ADDR, 64'h0200_BFF8, MMIO address of mtime
MTIMECMP_ADDR, 64'h0200_4000, MMIO address of mtimecmp
TICK_DIV, 1, clk cycles per mtime increment (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_inst_valid  in  1  valid instruction at commit point this cycle
i_pc  in  64  PC of that instruction
i_ecall  in  1  instruction is ecall (qualified by i_inst_valid)
i_mret  in  1  instruction is mret (qualified by i_inst_valid)
i_csr_mtvec  in  64  current mtvec
i_csr_mepc  in  64  current mepc
i_csr_mstatus  in  64  current mstatus
i_global_int_en  in  1  mstatus.MIE
i_mtime_int_en  in  1  mie.MTIE
i_mtime_int_pend  in  1  mip.MTIP
o_clint_csr_wen  out  1  CSR write strobe
o_clint_csr_waddr  out  12  CSR address (0x341 mepc, 0x342 mcause, 0x300 mstatus)
o_clint_csr_wdata  out  64  CSR write data
o_redirect_valid  out  1  one-cycle PC redirect
o_redirect_pc  out  64  redirect target
o_stall  out  1  freeze pipeline / inhibit CPU CSR writes
i_mmio_wen  in  1  MMIO write
i_mmio_addr  in  64  MMIO address
i_mmio_wdata  in  64  MMIO write data
o_mmio_rdata  out  64  MMIO read data (combinational)
o_timer_int  out  1  timer interrupt level

Behaviour:
- Reset: state=IDLE; mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; prescaler=0. All outputs are 0, except o_timer_int = (mtime>=mtimecmp) = 0.
- Timer:
  - mtime increments by 1 when the prescaler reaches TICK_DIV-1, then the prescaler clears. mtime wraps 2^64-1 to 0.
  - MMIO write to MTIME_ADDR or MTIMECMP_ADDR takes effect next cycle. An MMIO write to mtime wins over a same-cycle increment.
  - o_timer_int = (mtime >= mtimecmp), unsigned, from registered values.
  - o_mmio_rdata returns mtime or mtimecmp by address, else 0.
- Events, decoded in IDLE only:
  - int_take = i_inst_valid & i_global_int_en & i_mtime_int_en & i_mtime_int_pend
  - ecall_take = i_inst_valid & i_ecall
  - mret_take = i_inst_valid & i_mret
  - Priority: int_take > ecall_take > mret_take.
  - When any event is taken, latch pc_q=i_pc and cause_q:
    - interrupt: 64'h8000_0000_0000_0007
    - ecall: 64'd11
- FSM states: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, M_MSTATUS.
  - IDLE -> T_MEPC on int/ecall; IDLE -> M_MSTATUS on mret.
  - T_MEPC: write 0x341 = pc_q; -> T_MCAUSE.
  - T_MCAUSE: write 0x342 = cause_q; -> T_MSTATUS.
  - T_MSTATUS: write 0x300 = mstatus with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11. Same cycle: o_redirect_valid=1, o_redirect_pc = {i_csr_mtvec[63:2],2'b00}. -> IDLE.
  - M_MSTATUS: write 0x300 = mstatus with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11. Same cycle: o_redirect_valid=1, o_redirect_pc=i_csr_mepc. -> IDLE.
  - Trap latency: event cycle +3 to redirect. mret latency: +1.
- CSR write timing: o_clint_csr_wen is high exactly in T_MEPC, T_MCAUSE, T_MSTATUS and M_MSTATUS. All CSR write outputs are registered-state-driven (Moore).
- o_stall = (state!=IDLE) | int_take | ecall_take | mret_take. While stalled, the pipeline holds, does not retire, and issues no CPU CSR writes (the CPU port has priority in the CSR file).
- Events arriving while not in IDLE are ignored. The pipeline re-presents them after the redirect.
- Reset mid-sequence: return to IDLE immediately; no further CSR writes or redirect.

Test Plan:
- Reset, then idle 10 cycles with TICK_DIV=1 -> mtime reads 10; o_timer_int=0; no wen.
- MMIO mtimecmp=20, mtime=0 -> o_timer_int rises in the cycle mtime reaches 20. A same-cycle mtime write + tick loads the written value.
- ecall at pc=0x8000_0010, mtvec=0x8000_0103, mstatus=0x8 -> cycles +1..+3:
  - wen to 0x341 = 0x8000_0010
  - wen to 0x342 = 11
  - wen to 0x300 = 0x1880, with redirect to 0x8000_0100
  - o_stall high for cycles 0..3
- mret with mstatus=0x1880, mepc=0x8000_0014 -> next cycle: wen to 0x300 = 0x1888, redirect to 0x8000_0014, single cycle.
- Timer pending + MIE + MTIE with a simultaneous ecall -> mcause written = 0x8000_0000_0000_0007. With MIE=0 instead -> ecall path, mcause=11.
- Assert rst during T_MCAUSE -> no 0x300 write, no redirect; state IDLE; mtime=0.
